// File: rtl/csr_spike_spmv.sv
// Sparse matrix x binary spike-vector engine.
// A matrix of up to MAX_NNZ (row, col, val) entries is streamed in once, then
// any number of spike vectors are applied; each vector yields N_ROWS
// saturated row sums on a backpressured output stream.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_LOAD    | accepting matrix entries until one arrives with csr_last
// S_READY   | matrix held; waiting for a spike vector or reload
// S_COMPUTE | walking the entry store, one entry per cycle
// S_OUTPUT  | presenting row results 0..N_ROWS-1 on the output stream
module csr_spike_spmv #(
   parameter int N_ROWS  = 4,
   parameter int N_COLS  = 4,
   parameter int MAX_NNZ = 16,
   parameter int VAL_W   = 8,
   parameter int OUT_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      csr_valid,
   output logic                      csr_ready,
   input  logic [$clog2(N_ROWS)-1:0] csr_row,
   input  logic [$clog2(N_COLS)-1:0] csr_col,
   input  logic [VAL_W-1:0]          csr_val,
   input  logic                      csr_last,
   input  logic                      reload,
   input  logic                      spk_valid,
   output logic                      spk_ready,
   input  logic [N_COLS-1:0]         spk_vec,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(N_ROWS)-1:0] out_row,
   output logic [OUT_W-1:0]          out_data,
   output logic                      out_sat,
   output logic                      out_last,
   output logic                      busy,
   output logic                      err_overflow,
   output logic                      err_range
);

   localparam int RW    = $clog2(N_ROWS);
   localparam int CW    = $clog2(N_COLS);
   localparam int NW    = $clog2(MAX_NNZ + 1);
   localparam int AW    = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
   localparam int DEPTH = 1 << AW;
   localparam logic [OUT_W-1:0] OUT_MAX = '1;

   typedef enum logic [1:0] {S_LOAD, S_READY, S_COMPUTE, S_OUTPUT} state_t;

   state_t              state_q, state_d;
   logic [NW-1:0]       nnz_q, nnz_d;
   logic [NW-1:0]       k_q, k_d;
   logic [RW-1:0]       e_row_q [DEPTH];
   logic [RW-1:0]       e_row_d [DEPTH];
   logic [CW-1:0]       e_col_q [DEPTH];
   logic [CW-1:0]       e_col_d [DEPTH];
   logic [VAL_W-1:0]    e_val_q [DEPTH];
   logic [VAL_W-1:0]    e_val_d [DEPTH];
   logic [N_COLS-1:0]   spk_q, spk_d;
   logic [OUT_W-1:0]    res_q [N_ROWS];
   logic [OUT_W-1:0]    res_d [N_ROWS];
   logic [N_ROWS-1:0]   sat_q, sat_d;
   logic [RW-1:0]       orow_q, orow_d;
   logic                err_ovf_q, err_ovf_d;
   logic                err_rng_q, err_rng_d;

   logic                row_bad, col_bad, store_full;
   logic [AW-1:0]       k_idx;
   logic [RW-1:0]       cur_row;
   logic [CW-1:0]       cur_col;
   logic [VAL_W-1:0]    cur_val;
   logic [OUT_W:0]      sum;
   logic                hit, clamp, last_k, last_row;

   // Range checks only exist when the index width can encode illegal values.
   if ((1 << RW) > N_ROWS) begin : g_row_chk
      assign row_bad = (32'(csr_row) >= N_ROWS);
   end else begin : g_row_nochk
      assign row_bad = 1'b0;
   end

   if ((1 << CW) > N_COLS) begin : g_col_chk
      assign col_bad = (32'(csr_col) >= N_COLS);
   end else begin : g_col_nochk
      assign col_bad = 1'b0;
   end

   // Current entry under the compute pointer and its saturating sum.
   always_comb begin
      store_full = (nnz_q == NW'(MAX_NNZ));
      k_idx      = k_q[AW-1:0];
      cur_row    = e_row_q[k_idx];
      cur_col    = e_col_q[k_idx];
      cur_val    = e_val_q[k_idx];
      hit        = (nnz_q != '0) && spk_q[cur_col];
      sum        = {1'b0, res_q[cur_row]} + (OUT_W + 1)'(cur_val);
      clamp      = sum[OUT_W];
      last_k     = (nnz_q == '0) || (k_q == nnz_q - NW'(1));
      last_row   = (32'(orow_q) == N_ROWS - 1);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_LOAD;
         nnz_q     <= '0;
         k_q       <= '0;
         spk_q     <= '0;
         sat_q     <= '0;
         orow_q    <= '0;
         err_ovf_q <= 1'b0;
         err_rng_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            e_row_q[i] <= '0;
            e_col_q[i] <= '0;
            e_val_q[i] <= '0;
         end
         for (int i = 0; i < N_ROWS; i++) begin
            res_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         nnz_q     <= nnz_d;
         k_q       <= k_d;
         spk_q     <= spk_d;
         sat_q     <= sat_d;
         orow_q    <= orow_d;
         err_ovf_q <= err_ovf_d;
         err_rng_q <= err_rng_d;
         e_row_q   <= e_row_d;
         e_col_q   <= e_col_d;
         e_val_q   <= e_val_d;
         res_q     <= res_d;
      end
   end

   // Next-state logic; reload wins over a simultaneous spike in READY.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_LOAD:    if (csr_valid && csr_last) state_d = S_READY;
         S_READY: begin
            if (reload)         state_d = S_LOAD;
            else if (spk_valid) state_d = S_COMPUTE;
         end
         S_COMPUTE: if (last_k) state_d = S_OUTPUT;
         S_OUTPUT:  if (out_ready && last_row) state_d = S_READY;
         default:   state_d = S_LOAD;
      endcase
   end

   // Datapath updates: entry store, accumulation and output row pointer.
   always_comb begin
      nnz_d     = nnz_q;
      k_d       = k_q;
      spk_d     = spk_q;
      sat_d     = sat_q;
      orow_d    = orow_q;
      err_ovf_d = err_ovf_q;
      err_rng_d = err_rng_q;
      e_row_d   = e_row_q;
      e_col_d   = e_col_q;
      e_val_d   = e_val_q;
      res_d     = res_q;
      unique case (state_q)
         S_LOAD: begin
            if (csr_valid) begin
               if (row_bad || col_bad) err_rng_d = 1'b1;
               if (store_full)         err_ovf_d = 1'b1;
               if (!row_bad && !col_bad && !store_full) begin
                  e_row_d[nnz_q[AW-1:0]] = csr_row;
                  e_col_d[nnz_q[AW-1:0]] = csr_col;
                  e_val_d[nnz_q[AW-1:0]] = csr_val;
                  nnz_d                  = nnz_q + NW'(1);
               end
            end
         end
         S_READY: begin
            if (reload) begin
               nnz_d     = '0;
               err_ovf_d = 1'b0;
               err_rng_d = 1'b0;
            end else if (spk_valid) begin
               spk_d = spk_vec;
               sat_d = '0;
               k_d   = '0;
               for (int i = 0; i < N_ROWS; i++) begin
                  res_d[i] = '0;
               end
            end
         end
         S_COMPUTE: begin
            if (hit) begin
               res_d[cur_row] = clamp ? OUT_MAX : sum[OUT_W-1:0];
               if (clamp) sat_d[cur_row] = 1'b1;
            end
            k_d = k_q + NW'(1);
            if (last_k) orow_d = '0;
         end
         S_OUTPUT: begin
            if (out_ready) orow_d = last_row ? '0 : orow_q + RW'(1);
         end
         default: ;
      endcase
   end

   // Stream handshakes and status outputs decoded from state.
   always_comb begin
      csr_ready    = (state_q == S_LOAD);
      spk_ready    = (state_q == S_READY);
      out_valid    = (state_q == S_OUTPUT);
      busy         = (state_q == S_COMPUTE) || (state_q == S_OUTPUT);
      out_row      = orow_q;
      out_data     = res_q[orow_q];
      out_sat      = sat_q[orow_q];
      out_last     = (state_q == S_OUTPUT) && last_row;
      err_overflow = err_ovf_q;
      err_range    = err_rng_q;
   end

endmodule

// File: tb/tb_csr_spike_spmv.sv
// Directed bench for csr_spike_spmv: table of spike vectors against a fixed
// matrix, plus hand sequences for saturation, overflow, reload priority,
// backpressure, mid-compute reset and (on a 3-row build) range errors.
module tb_csr_spike_spmv;

   logic       clk = 1'b0;
   logic       rst;
   always #5 clk = ~clk;

   logic       csr_valid, csr_ready, csr_last, reload;
   logic [1:0] csr_row, csr_col, out_row;
   logic [7:0] csr_val, out_data;
   logic       spk_valid, spk_ready, out_valid, out_ready;
   logic [3:0] spk_vec;
   logic       out_sat, out_last, busy, err_overflow, err_range;

   logic       b_csr_valid, b_csr_ready, b_csr_last, b_reload;
   logic [1:0] b_csr_row, b_csr_col, b_out_row;
   logic [7:0] b_csr_val, b_out_data;
   logic       b_spk_valid, b_spk_ready, b_out_valid, b_out_ready;
   logic [3:0] b_spk_vec;
   logic       b_out_sat, b_out_last, b_busy, b_err_overflow, b_err_range;

   csr_spike_spmv u_dut (
      .clk(clk), .rst(rst),
      .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_row(csr_row),
      .csr_col(csr_col), .csr_val(csr_val), .csr_last(csr_last),
      .reload(reload), .spk_valid(spk_valid), .spk_ready(spk_ready),
      .spk_vec(spk_vec), .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_data(out_data), .out_sat(out_sat),
      .out_last(out_last), .busy(busy), .err_overflow(err_overflow),
      .err_range(err_range)
   );

   csr_spike_spmv #(.N_ROWS(3), .N_COLS(4), .MAX_NNZ(4), .VAL_W(8), .OUT_W(8)) u_dut3 (
      .clk(clk), .rst(rst),
      .csr_valid(b_csr_valid), .csr_ready(b_csr_ready), .csr_row(b_csr_row),
      .csr_col(b_csr_col), .csr_val(b_csr_val), .csr_last(b_csr_last),
      .reload(b_reload), .spk_valid(b_spk_valid), .spk_ready(b_spk_ready),
      .spk_vec(b_spk_vec), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_row(b_out_row), .out_data(b_out_data), .out_sat(b_out_sat),
      .out_last(b_out_last), .busy(b_busy), .err_overflow(b_err_overflow),
      .err_range(b_err_range)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] vec;
      int         data [4];
      logic [3:0] sat;
      int         stall_row;
   } vec_t;

   vec_t vt [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic send_entry(input int r, input int c, input int v, input bit last);
      int n;
      csr_valid = 1'b1;
      csr_row   = 2'(r);
      csr_col   = 2'(c);
      csr_val   = 8'(v);
      csr_last  = last;
      n = 0;
      while (csr_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("entry_ready", 32'(csr_ready), 1);
      @(negedge clk);
      csr_valid = 1'b0;
      csr_last  = 1'b0;
   endtask

   task automatic send_spike(input logic [3:0] vec);
      int n;
      spk_valid = 1'b1;
      spk_vec   = vec;
      n = 0;
      while (spk_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("spike_ready", 32'(spk_ready), 1);
      @(negedge clk);
      spk_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input int d [4], input logic [3:0] s, input int stall_row);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      for (int r = 0; r < 4; r++) begin
         check($sformatf("%s r%0d out_valid", tag, r), 32'(out_valid), 1);
         check($sformatf("%s r%0d out_row", tag, r), 32'(out_row), 32'(r));
         check($sformatf("%s r%0d out_data", tag, r), 32'(out_data), 32'(d[r]));
         check($sformatf("%s r%0d out_sat", tag, r), 32'(out_sat), 32'(s[r]));
         check($sformatf("%s r%0d out_last", tag, r), 32'(out_last), 32'(r == 3));
         check($sformatf("%s r%0d busy", tag, r), 32'(busy), 1);
         if (r == stall_row) begin
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check($sformatf("%s stall%0d out_row", tag, i), 32'(out_row), 32'(r));
               check($sformatf("%s stall%0d out_data", tag, i), 32'(out_data), 32'(d[r]));
               check($sformatf("%s stall%0d valid", tag, i), 32'(out_valid), 1);
               check($sformatf("%s stall%0d busy", tag, i), 32'(busy), 1);
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
      end
      check($sformatf("%s done out_valid", tag), 32'(out_valid), 0);
      check($sformatf("%s done spk_ready", tag), 32'(spk_ready), 1);
      check($sformatf("%s done busy", tag), 32'(busy), 0);
   endtask

   task automatic load_default();
      send_entry(0, 0, 5, 1'b0);
      send_entry(0, 2, 3, 1'b0);
      send_entry(1, 1, 7, 1'b0);
      send_entry(2, 3, 9, 1'b0);
      send_entry(3, 0, 1, 1'b0);
      send_entry(3, 3, 2, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int er [3];
      int ec [3];
      int ev [3];
      int eb [3];
      int n;

      vt[0].vec = 4'b1001; vt[0].data = '{5, 0, 9, 3}; vt[0].sat = 4'b0000; vt[0].stall_row = -1;
      vt[1].vec = 4'b0110; vt[1].data = '{3, 7, 0, 0}; vt[1].sat = 4'b0000; vt[1].stall_row = -1;
      vt[2].vec = 4'b1111; vt[2].data = '{8, 7, 9, 3}; vt[2].sat = 4'b0000; vt[2].stall_row = 2;
      vt[3].vec = 4'b0000; vt[3].data = '{0, 0, 0, 0}; vt[3].sat = 4'b0000; vt[3].stall_row = -1;
      vt[4].vec = 4'b0100; vt[4].data = '{3, 0, 0, 0}; vt[4].sat = 4'b0000; vt[4].stall_row = -1;

      rst = 1'b1;
      csr_valid = 0; csr_row = 0; csr_col = 0; csr_val = 0; csr_last = 0;
      reload = 0; spk_valid = 0; spk_vec = 0; out_ready = 1'b1;
      b_csr_valid = 0; b_csr_row = 0; b_csr_col = 0; b_csr_val = 0; b_csr_last = 0;
      b_reload = 0; b_spk_valid = 0; b_spk_vec = 0; b_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst csr_ready", 32'(csr_ready), 1);
      check("rst spk_ready", 32'(spk_ready), 0);
      check("rst out_valid", 32'(out_valid), 0);
      check("rst out_data", 32'(out_data), 0);
      check("rst out_last", 32'(out_last), 0);
      check("rst busy", 32'(busy), 0);
      check("rst err_overflow", 32'(err_overflow), 0);
      check("rst err_range", 32'(err_range), 0);

      // Spikes are ignored while no matrix is loaded.
      spk_valid = 1'b1; spk_vec = 4'b1111;
      repeat (3) @(negedge clk);
      check("load spk ignored spk_ready", 32'(spk_ready), 0);
      check("load spk ignored busy", 32'(busy), 0);
      spk_valid = 1'b0;

      load_default();
      check("loaded spk_ready", 32'(spk_ready), 1);
      check("loaded csr_ready", 32'(csr_ready), 0);

      for (int t = 0; t < 5; t++) begin
         send_spike(vt[t].vec);
         collect($sformatf("vec%0d", t), vt[t].data, vt[t].sat, vt[t].stall_row);
      end

      // reload beats a simultaneous spike.
      reload = 1'b1; spk_valid = 1'b1; spk_vec = 4'b1111;
      @(negedge clk);
      reload = 1'b0; spk_valid = 1'b0;
      check("reload csr_ready", 32'(csr_ready), 1);
      check("reload spk_ready", 32'(spk_ready), 0);
      check("reload busy", 32'(busy), 0);
      check("reload out_valid", 32'(out_valid), 0);

      // Saturation on row1; row2 lands exactly on the maximum without clamping.
      send_entry(1, 0, 200, 1'b0);
      send_entry(1, 1, 100, 1'b0);
      send_entry(1, 2, 1, 1'b0);
      send_entry(2, 0, 255, 1'b1);
      send_spike(4'b0111);
      collect("sat", '{0, 255, 255, 0}, 4'b0010, -1);

      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;

      // Store capacity: 17th entry is dropped.
      for (int i = 0; i < 17; i++) begin
         if (i == 16) check("ovf before 17th", 32'(err_overflow), 0);
         send_entry(0, 0, 1, i == 16);
      end
      check("ovf err_overflow", 32'(err_overflow), 1);
      check("ovf err_range", 32'(err_range), 0);
      check("ovf spk_ready", 32'(spk_ready), 1);
      send_spike(4'b0001);
      collect("ovf", '{16, 0, 0, 0}, 4'b0000, -1);
      check("ovf sticky", 32'(err_overflow), 1);

      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      check("ovf cleared by reload", 32'(err_overflow), 0);

      // Reset while computing.
      load_default();
      send_spike(4'b1001);
      check("compute busy", 32'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst csr_ready", 32'(csr_ready), 1);
      check("midrst out_valid", 32'(out_valid), 0);
      check("midrst busy", 32'(busy), 0);
      check("midrst spk_ready", 32'(spk_ready), 0);
      rst = 1'b0;
      spk_valid = 1'b1; spk_vec = 4'b1001;
      repeat (4) @(negedge clk);
      check("postrst spk_ready", 32'(spk_ready), 0);
      check("postrst busy", 32'(busy), 0);
      spk_valid = 1'b0;
      send_entry(1, 2, 11, 1'b1);
      send_spike(4'b0100);
      collect("postrst", '{0, 11, 0, 0}, 4'b0000, -1);

      // Three-row build: entry with row=3 is out of range and excluded.
      er = '{0, 3, 2}; ec = '{0, 1, 1}; ev = '{4, 50, 6};
      for (int i = 0; i < 3; i++) begin
         b_csr_valid = 1'b1;
         b_csr_row   = 2'(er[i]);
         b_csr_col   = 2'(ec[i]);
         b_csr_val   = 8'(ev[i]);
         b_csr_last  = (i == 2);
         check($sformatf("r3 entry%0d ready", i), 32'(b_csr_ready), 1);
         @(negedge clk);
      end
      b_csr_valid = 1'b0; b_csr_last = 1'b0;
      check("r3 err_range", 32'(b_err_range), 1);
      check("r3 err_overflow", 32'(b_err_overflow), 0);
      check("r3 spk_ready", 32'(b_spk_ready), 1);
      b_spk_valid = 1'b1; b_spk_vec = 4'b0011;
      @(negedge clk);
      b_spk_valid = 1'b0;
      n = 0;
      while (b_out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      eb = '{4, 0, 6};
      for (int r = 0; r < 3; r++) begin
         check($sformatf("r3 r%0d out_valid", r), 32'(b_out_valid), 1);
         check($sformatf("r3 r%0d out_row", r), 32'(b_out_row), 32'(r));
         check($sformatf("r3 r%0d out_data", r), 32'(b_out_data), 32'(eb[r]));
         check($sformatf("r3 r%0d out_last", r), 32'(b_out_last), 32'(r == 2));
         @(negedge clk);
      end
      check("r3 done out_valid", 32'(b_out_valid), 0);
      check("r3 err_range sticky", 32'(b_err_range), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
